mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
Memory-side responder for the cache request protocol. It serves instruction-fetch requests (iREN/iaddr → iwait/iload) and data requests (dREN/dWEN/daddr/dstore → dwait/dload) from the caches. It arbitrates a single RAM port between the two requesters and generates the wait/load handshake that the caches stall on. It sits between the icache/dcache and RAM.

Parameters:
WORD_W, 32, data and address width
STARVE_MAX, 4, consecutive data grants allowed while an instruction request is pending before the instruction side is forced

Ports:
CLK  in  1  clock
nRST  in  1  reset, synchronous, active-low
iREN  in  1  instruction read request
iaddr  in  WORD_W  instruction address
iwait  out  1  high = instruction request not complete
iload  out  WORD_W  instruction data, valid when iREN & ~iwait
dREN  in  1  data read request
dWEN  in  1  data write request
daddr  in  WORD_W  data address
dstore  in  WORD_W  write data
dwait  out  1  high = data request not complete
dload  out  WORD_W  read data, valid when dREN & ~dwait
ramREN  out  1  RAM read enable
ramWEN  out  1  RAM write enable
ramaddr  out  WORD_W  RAM address
ramstore  out  WORD_W  RAM write data
ramload  in  WORD_W  RAM read data
ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR

Behaviour:
- Clock and reset: one clock, CLK. Reset nRST is synchronous and active-low.
- State register: states IDLE, ISERV, DSERV. Starvation counter starve_cnt has width clog2(STARVE_MAX+1).
- Reset (nRST low at a CLK edge): state=IDLE, starve_cnt=0. Reset asserted mid-transaction aborts it; no wait line drops.
- Output values in IDLE (and therefore out of reset): iwait=1, dwait=1, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
- iload and dload are always driven from ramload.
- IDLE transitions:
  - (dREN|dWEN) & ~(iREN & starve_cnt==STARVE_MAX) → DSERV.
  - Else iREN → ISERV.
  - Else stay in IDLE.
  - Requests seen in IDLE are never completed in the same cycle.
- ISERV:
  - Drives ramREN=1, ramWEN=0, ramaddr=iaddr. dwait=1.
  - iwait = ~(ramstate==ACCESS).
  - On ACCESS: go to IDLE, starve_cnt←0.
- DSERV:
  - Drives ramaddr=daddr, ramstore=dstore, ramWEN=dWEN, ramREN=dREN&~dWEN. dREN&dWEN together is treated as a write. iwait=1.
  - dwait = ~(ramstate==ACCESS).
  - On ACCESS: go to IDLE. If iREN is high that cycle, starve_cnt increments, saturating at STARVE_MAX.
- Completion handshake: wait is low for exactly the one cycle that ramstate==ACCESS. Outputs are combinational from state and ramstate.
- Minimum latency:
  - Request first seen in cycle N; the earliest wait-low is cycle N+1.
  - Back-to-back transactions have one IDLE cycle between them.
- BUSY or FREE while serving: hold state and hold all RAM outputs.
- ERROR while serving: hold state with wait high. RAM outputs stay asserted, so the access is retried implicitly.
- Abort on dropped request: in ISERV with iREN low, or in DSERV with dREN|dWEN low, go to IDLE without dropping wait. starve_cnt is unchanged.
- Address stability: requesters hold address and data stable while wait is high (protocol rule). ramaddr follows the inputs combinationally.
- starve_cnt clears in IDLE when iREN is low.
- No preemption: a granted transaction runs to ACCESS or abort.

Decomposition:
- ramstate_t already exists in cpu_types_pkg.
- Add to cpu_types_pkg: memresp_state_t enum {IDLE, ISERV, DSERV}.
- No sub-module. A single always_ff holds state and starve_cnt, and a single always_comb computes next state and outputs.

Test Plan:
- Reset: hold nRST low 2 cycles with iREN=1 → iwait=1, dwait=1, ramREN=0, ramWEN=0, ramaddr=0. State stays IDLE until the edge after nRST rises.
- Instruction fetch: iREN=1, iaddr=0x40, RAM gives BUSY 2 cycles then ACCESS with ramload=0xDEADBEEF → ramaddr=0x40, ramREN=1 from cycle 1; iwait low only in cycle 3 with iload=0xDEADBEEF.
- Simultaneous requests: iREN=1 and dWEN=1 with daddr=0x80, dstore=0x1234 in the same cycle → DSERV first (ramWEN=1, ramstore=0x1234). After dwait drops, one IDLE cycle, then ISERV for iaddr.
- Starvation: iREN held high, dREN re-asserted every cycle, each RAM access 1 cycle → after 4 data completions, the next grant is ISERV; starve_cnt returns to 0 on its completion.
- ERROR then ACCESS: dREN=1, ramstate=ERROR 3 cycles then ACCESS → dwait high through the errors, RAM outputs unchanged, dwait low in the ACCESS cycle only.
- Abort: in ISERV, drop iREN before ACCESS → next cycle state is IDLE, iwait never drops, ramREN=0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg
//   Shared CPU-side types.
//   ramstate_t      : status reported by the RAM model on every cycle
//   memresp_state_t : arbitration state of the memory responder
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISERV = 2'd1,
    DSERV = 2'd2
  } memresp_state_t;

endpackage

// File: rtl/mem_responder_if.sv
// mem_responder_if
//   Bundles the cache request/response handshake and the RAM port that the
//   memory responder arbitrates.
//   Cache side : iREN, iaddr, iwait, iload, dREN, dWEN, daddr, dstore, dwait, dload
//   RAM side   : ramREN, ramWEN, ramaddr, ramstore, ramload, ramstate
//   modport slave  : the responder (consumes requests, drives waits and RAM)
//   modport master : the caches plus RAM (drive requests, RAM data and status)
interface mem_responder_if import cpu_types_pkg::*; #(
  parameter int WORD_W = 32
) ();

  logic              iREN;
  logic [WORD_W-1:0] iaddr;
  logic              iwait;
  logic [WORD_W-1:0] iload;

  logic              dREN;
  logic              dWEN;
  logic [WORD_W-1:0] daddr;
  logic [WORD_W-1:0] dstore;
  logic              dwait;
  logic [WORD_W-1:0] dload;

  logic              ramREN;
  logic              ramWEN;
  logic [WORD_W-1:0] ramaddr;
  logic [WORD_W-1:0] ramstore;
  logic [WORD_W-1:0] ramload;
  ramstate_t         ramstate;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

endinterface

// File: rtl/mem_responder.sv
// mem_responder
//   Memory-side responder shared by the icache and dcache. It grants the single
//   RAM port to one requester at a time and produces the wait/load handshake
//   the caches stall on. Data requests win ties, except when the instruction
//   side has been passed over STARVE_MAX times in a row.
//   Ports:
//     CLK  : clock
//     nRST : synchronous active-low reset
//     mif  : mem_responder_if.slave (cache requests/responses and RAM port)
module mem_responder import cpu_types_pkg::*; #(
  parameter int WORD_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input logic            CLK,
  input logic            nRST,
  mem_responder_if.slave mif
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  memresp_state_t   state, next_state;
  logic [CNT_W-1:0] starve_cnt, next_starve_cnt;
  logic             drequest;
  logic             istarved;

  assign mif.iload = mif.ramload;
  assign mif.dload = mif.ramload;

  assign drequest = mif.dREN | mif.dWEN;
  assign istarved = mif.iREN && (starve_cnt == STARVE_LIM);

  // State and starvation counter; reset may land mid-transaction and simply
  // returns to IDLE without completing anything.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      state      <= next_state;
      starve_cnt <= next_starve_cnt;
    end
  end

  // Arbitration and handshake. Waits only drop in the single ACCESS cycle of
  // the granted side; a dropped request aborts with the wait still high.
  always_comb begin
    next_state      = state;
    next_starve_cnt = starve_cnt;
    mif.iwait       = 1'b1;
    mif.dwait       = 1'b1;
    mif.ramREN      = 1'b0;
    mif.ramWEN      = 1'b0;
    mif.ramaddr     = WORD_W'(0);
    mif.ramstore    = WORD_W'(0);

    case (state)
      IDLE: begin
        if (!mif.iREN) begin
          next_starve_cnt = '0;
        end
        if (drequest && !istarved) begin
          next_state = DSERV;
        end else if (mif.iREN) begin
          next_state = ISERV;
        end
      end

      ISERV: begin
        mif.ramREN  = 1'b1;
        mif.ramaddr = mif.iaddr;
        if (!mif.iREN) begin
          next_state = IDLE;
        end else if (mif.ramstate == ACCESS) begin
          mif.iwait       = 1'b0;
          next_state      = IDLE;
          next_starve_cnt = '0;
        end
      end

      DSERV: begin
        // A simultaneous read and write is served as a write.
        mif.ramaddr  = mif.daddr;
        mif.ramstore = mif.dstore;
        mif.ramWEN   = mif.dWEN;
        mif.ramREN   = mif.dREN & ~mif.dWEN;
        if (!drequest) begin
          next_state = IDLE;
        end else if (mif.ramstate == ACCESS) begin
          mif.dwait  = 1'b0;
          next_state = IDLE;
          if (mif.iREN && (starve_cnt != STARVE_LIM)) begin
            next_starve_cnt = starve_cnt + 1'b1;
          end
        end
      end

      default: begin
        next_state = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder
//   Directed bench for mem_responder: reset, instruction fetch with RAM
//   latency, data/instruction tie-break, starvation override, ERROR retry,
//   request abort and mid-transaction reset.
module tb_mem_responder;
  import cpu_types_pkg::*;

  logic CLK;
  logic nRST;
  int   checkCount;
  int   errorCount;

  mem_responder_if #(.WORD_W(32)) mif ();

  mem_responder #(.WORD_W(32), .STARVE_MAX(4)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .mif  (mif)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Compare one observed value with its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Advance past the next rising edge, leaving time to drive inputs.
  task automatic applyStimulus();
    @(posedge CLK);
    #1;
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle();
    #1;
  endtask

  // Check the full RAM-side picture at once.
  task automatic checkRam(input string tag, input logic ren, input logic wen,
                          input logic [31:0] addr);
    checkOutput({tag, ".ramREN"}, {31'd0, mif.ramREN}, {31'd0, ren});
    checkOutput({tag, ".ramWEN"}, {31'd0, mif.ramWEN}, {31'd0, wen});
    checkOutput({tag, ".ramaddr"}, mif.ramaddr, addr);
  endtask

  task automatic checkWaits(input string tag, input logic iw, input logic dw);
    checkOutput({tag, ".iwait"}, {31'd0, mif.iwait}, {31'd0, iw});
    checkOutput({tag, ".dwait"}, {31'd0, mif.dwait}, {31'd0, dw});
  endtask

  initial begin
    checkCount   = 0;
    errorCount   = 0;
    nRST         = 1'b0;
    mif.iREN     = 1'b1;
    mif.iaddr    = 32'h40;
    mif.dREN     = 1'b0;
    mif.dWEN     = 1'b0;
    mif.daddr    = 32'h0;
    mif.dstore   = 32'h0;
    mif.ramload  = 32'h0;
    mif.ramstate = FREE;

    // Reset held for two edges with an instruction request pending.
    for (int i = 0; i < 2; i++) begin
      applyStimulus();
      settle();
      checkWaits("reset", 1'b1, 1'b1);
      checkRam("reset", 1'b0, 1'b0, 32'h0);
      checkOutput("reset.ramstore", mif.ramstore, 32'h0);
    end

    // Release reset: still IDLE for this cycle (request seen, cycle 0).
    nRST         = 1'b1;
    mif.ramstate = BUSY;
    settle();
    checkRam("rel", 1'b0, 1'b0, 32'h0);
    checkWaits("rel", 1'b1, 1'b1);

    // Instruction fetch: BUSY for cycles 1 and 2, ACCESS in cycle 3.
    for (int i = 1; i <= 2; i++) begin
      applyStimulus();
      settle();
      checkRam("ifetch.busy", 1'b1, 1'b0, 32'h40);
      checkWaits("ifetch.busy", 1'b1, 1'b1);
    end
    applyStimulus();
    mif.ramstate = ACCESS;
    mif.ramload  = 32'hDEADBEEF;
    settle();
    checkWaits("ifetch.acc", 1'b0, 1'b1);
    checkOutput("ifetch.iload", mif.iload, 32'hDEADBEEF);
    checkRam("ifetch.acc", 1'b1, 1'b0, 32'h40);

    applyStimulus();
    mif.iREN     = 1'b0;
    mif.ramstate = FREE;
    settle();
    checkRam("ifetch.idle", 1'b0, 1'b0, 32'h0);
    checkWaits("ifetch.idle", 1'b1, 1'b1);

    // Simultaneous requests: data side wins, then one IDLE, then fetch.
    mif.iREN     = 1'b1;
    mif.iaddr    = 32'h44;
    mif.dWEN     = 1'b1;
    mif.daddr    = 32'h80;
    mif.dstore   = 32'h1234;
    mif.ramstate = ACCESS;
    settle();
    checkWaits("simul.seen", 1'b1, 1'b1);
    applyStimulus();
    settle();
    checkRam("simul.d", 1'b0, 1'b1, 32'h80);
    checkOutput("simul.ramstore", mif.ramstore, 32'h1234);
    checkWaits("simul.d", 1'b1, 1'b0);
    applyStimulus();
    mif.dWEN = 1'b0;
    settle();
    checkRam("simul.gap", 1'b0, 1'b0, 32'h0);
    checkWaits("simul.gap", 1'b1, 1'b1);
    applyStimulus();
    settle();
    checkRam("simul.i", 1'b1, 1'b0, 32'h44);
    checkWaits("simul.i", 1'b0, 1'b1);
    applyStimulus();
    mif.iREN = 1'b0;
    settle();
    checkRam("simul.end", 1'b0, 1'b0, 32'h0);

    // Starvation: four data grants, then the instruction side is forced.
    mif.iREN  = 1'b1;
    mif.iaddr = 32'h48;
    mif.dREN  = 1'b1;
    mif.daddr = 32'h90;
    for (int k = 0; k < 4; k++) begin
      applyStimulus();
      settle();
      checkRam("starve.d", 1'b1, 1'b0, 32'h90);
      checkWaits("starve.d", 1'b1, 1'b0);
      applyStimulus();
      settle();
      checkRam("starve.gap", 1'b0, 1'b0, 32'h0);
    end
    applyStimulus();
    settle();
    checkRam("starve.forced", 1'b1, 1'b0, 32'h48);
    checkWaits("starve.forced", 1'b0, 1'b1);
    applyStimulus();
    settle();
    checkRam("starve.gap2", 1'b0, 1'b0, 32'h0);
    // Counter cleared by the fetch, so data wins again.
    applyStimulus();
    settle();
    checkRam("starve.cleared", 1'b1, 1'b0, 32'h90);
    applyStimulus();
    mif.iREN = 1'b0;
    mif.dREN = 1'b0;
    settle();
    checkWaits("starve.end", 1'b1, 1'b1);

    // ERROR three cycles then ACCESS on a data read.
    mif.dREN     = 1'b1;
    mif.daddr    = 32'hA0;
    mif.ramstate = ERROR;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      settle();
      checkRam("err.retry", 1'b1, 1'b0, 32'hA0);
      checkWaits("err.retry", 1'b1, 1'b1);
    end
    applyStimulus();
    mif.ramstate = ACCESS;
    mif.ramload  = 32'hCAFEF00D;
    settle();
    checkWaits("err.acc", 1'b1, 1'b0);
    checkOutput("err.dload", mif.dload, 32'hCAFEF00D);
    applyStimulus();
    mif.dREN = 1'b0;
    settle();
    checkWaits("err.idle", 1'b1, 1'b1);
    checkRam("err.idle", 1'b0, 1'b0, 32'h0);

    // Abort: drop iREN while the RAM is still busy.
    mif.iREN     = 1'b1;
    mif.iaddr    = 32'h60;
    mif.ramstate = BUSY;
    applyStimulus();
    settle();
    checkRam("abort.serv", 1'b1, 1'b0, 32'h60);
    mif.iREN = 1'b0;
    settle();
    checkWaits("abort.drop", 1'b1, 1'b1);
    applyStimulus();
    mif.ramstate = ACCESS;
    settle();
    checkRam("abort.idle", 1'b0, 1'b0, 32'h0);
    checkWaits("abort.idle", 1'b1, 1'b1);

    // Reset asserted mid-transaction aborts without completing.
    mif.dREN     = 1'b1;
    mif.daddr    = 32'hB0;
    mif.ramstate = BUSY;
    applyStimulus();
    nRST = 1'b0;
    settle();
    checkRam("midrst.serv", 1'b1, 1'b0, 32'hB0);
    applyStimulus();
    mif.ramstate = ACCESS;
    settle();
    checkRam("midrst.idle", 1'b0, 1'b0, 32'h0);
    checkWaits("midrst.idle", 1'b1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
